// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface mdu_iterative_if #(parameter int XLEN = 32);
  logic            START;
  logic [2:0]      FUNCT3;
  logic [XLEN-1:0] OPA;
  logic [XLEN-1:0] OPB;
  logic [4:0]      RD_IN;
  logic            KILL;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;
  logic [4:0]      RD_OUT;

  modport master (output START, FUNCT3, OPA, OPB, RD_IN, KILL,
                  input  BUSY, DONE, RESULT, RD_OUT);
  modport slave  (input  START, FUNCT3, OPA, OPB, RD_IN, KILL,
                  output BUSY, DONE, RESULT, RD_OUT);
endinterface

// File: rtl/mdu_iterative.sv
// RV32IM multiply/divide unit: 32-step shift-add multiply and restoring divide on magnitudes.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic           CLK,
  input  logic           RESET,
  mdu_iterative_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opd_q, opd_d;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              done_q, done_d;

  logic              signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] mul_step, div_step, acc_neg;
  logic [XLEN-1:0]   div_sel, fin_val;
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

  always_comb begin
    signed_a = (bus.FUNCT3 == 3'b001) || (bus.FUNCT3 == 3'b010) ||
               (bus.FUNCT3 == 3'b100) || (bus.FUNCT3 == 3'b110);
    signed_b = (bus.FUNCT3 == 3'b001) || (bus.FUNCT3 == 3'b100) || (bus.FUNCT3 == 3'b110);
    sign_a   = signed_a & bus.OPA[XLEN-1];
    sign_b   = signed_b & bus.OPB[XLEN-1];
    mag_a    = sign_a ? -bus.OPA : bus.OPA;
    mag_b    = sign_b ? -bus.OPB : bus.OPB;
    div_ovf  = !bus.FUNCT3[0] && (bus.OPA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.OPB == '1);
`ifdef MDU_FAST_MUL_EN
    fast_a    = {{XLEN{sign_a}}, bus.OPA};
    fast_b    = {{XLEN{signed_b & bus.OPB[XLEN-1]}}, bus.OPB};
    fast_prod = fast_a * fast_b;
`endif
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opd_q};
    div_step  = div_trial[XLEN+1] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_neg   = -acc_q;
    div_sel   = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (op_q[2])
      fin_val = neg_q ? -div_sel : div_sel;
    else if (op_q[1:0] == 2'b00)
      fin_val = neg_q ? acc_neg[XLEN-1:0] : acc_q[XLEN-1:0];
    else
      fin_val = neg_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START && !bus.KILL) begin
          op_d  = bus.FUNCT3;
          rd_d  = bus.RD_IN;
          cnt_d = '0;
          if (bus.FUNCT3[2]) begin
            opd_d = mag_b;
            if (bus.OPB == '0) begin
              acc_d   = {bus.OPA, {XLEN{1'b1}}};
              neg_d   = 1'b0;
              state_d = FIN;
            end else if (div_ovf) begin
              acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
              neg_d   = 1'b0;
              state_d = FIN;
            end else begin
              acc_d   = {{XLEN{1'b0}}, mag_a};
              neg_d   = bus.FUNCT3[1] ? sign_a : (sign_a ^ sign_b);
              state_d = CALC;
            end
          end else begin
`ifdef MDU_FAST_MUL_EN
            acc_d   = fast_prod;
            neg_d   = 1'b0;
            state_d = FIN;
`else
            opd_d   = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            neg_d   = sign_a ^ sign_b;
            state_d = CALC;
`endif
          end
        end
      end
      CALC: begin
        if (bus.KILL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = op_q[2] ? div_step : mul_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1))
            state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!bus.KILL) begin
          result_d = fin_val;
          rd_out_d = rd_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign bus.BUSY   = (state_q != IDLE);
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;
  assign bus.RD_OUT = rd_out_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed vector table, kill/reset/back-to-back sequences, random ops vs. arithmetic model.
module tb_mdu_iterative;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_iterative_if bus();
  mdu_iterative dut (.CLK(clk), .RESET(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
`ifdef MDU_FAST_MUL_EN
    if (!f3[2])
      return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called mid-cycle (1 time unit after a rising edge); returns mid-cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    int lat, busy_cnt;
    bit seen;
    logic [31:0] exp_r;
    int exp_l;
    exp_r = ref_result(f3, a, b);
    exp_l = ref_latency(f3, a, b);
    bus.START = 1'b1; bus.FUNCT3 = f3; bus.OPA = a; bus.OPB = b; bus.RD_IN = rd;
    @(posedge clk); #1;
    bus.START = 1'b0;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.BUSY) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      if (bus.DONE) seen = 1'b1;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_l));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_l));
    check({tag, " result"}, 64'(bus.RESULT), 64'(exp_r));
    check({tag, " rd_out"}, 64'(bus.RD_OUT), 64'(rd));
    check({tag, " busy_at_done"}, 64'(bus.BUSY), 64'd0);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'(bus.DONE), 64'd0);
    check({tag, " result_hold"}, 64'(bus.RESULT), 64'(exp_r));
    last_res = exp_r;
    last_rd  = rd;
  endtask

  // Start DIVU 100/7, ignore a START at cycle 10, then abort at cycle 15 with KILL or RESET.
  task automatic abort_seq(input bit use_reset, input string tag);
    int done_cnt;
    bus.START = 1'b1; bus.FUNCT3 = 3'd5; bus.OPA = 32'd100; bus.OPB = 32'd7; bus.RD_IN = 5'd3;
    @(posedge clk); #1;
    bus.START = 1'b0;
    for (int c = 1; c < 15; c++) begin
      if (c == 10) begin
        bus.START = 1'b1; bus.FUNCT3 = 3'd0; bus.OPA = 32'd3; bus.OPB = 32'd3; bus.RD_IN = 5'd7;
      end
      @(posedge clk); #1;
      bus.START = 1'b0;
      if (c == 10) check({tag, " busy_after_ignored_start"}, 64'(bus.BUSY), 64'd1);
    end
    if (use_reset) rst = 1'b1; else bus.KILL = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.KILL = 1'b0;
    if (use_reset) begin
      last_res = '0;
      last_rd  = '0;
    end
    check({tag, " busy_after_abort"}, 64'(bus.BUSY), 64'd0);
    check({tag, " done_after_abort"}, 64'(bus.DONE), 64'd0);
    check({tag, " result_after_abort"}, 64'(bus.RESULT), 64'(last_res));
    check({tag, " rd_after_abort"}, 64'(bus.RD_OUT), 64'(last_rd));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.DONE) done_cnt++;
    end
    check({tag, " no_done"}, 64'(done_cnt), 64'd0);
    check({tag, " result_kept"}, 64'(bus.RESULT), 64'(last_res));
  endtask

  initial begin
    int lat;
    bit seen;
    bus.START = 1'b0; bus.FUNCT3 = '0; bus.OPA = '0; bus.OPB = '0; bus.RD_IN = '0; bus.KILL = 1'b0;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  5'd1,  32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd4,  32'hFFFF_FFFF};
    vecs[4]  = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0001};
    vecs[5]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD};
    vecs[6]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF};
    vecs[7]  = '{3'd5, 32'd100,        32'd7,          5'd9,  32'd14};
    vecs[8]  = '{3'd7, 32'd100,        32'd7,          5'd10, 32'd2};
    vecs[9]  = '{3'd4, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF};
    vecs[10] = '{3'd6, 32'd5,          32'd0,          5'd12, 32'd5};
    vecs[11] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000};
    vecs[12] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0};
    vecs[13] = '{3'd5, 32'd5,          32'd0,          5'd15, 32'hFFFF_FFFF};
    vecs[14] = '{3'd7, 32'd5,          32'd0,          5'd31, 32'd5};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset busy", 64'(bus.BUSY), 64'd0);
    check("reset done", 64'(bus.DONE), 64'd0);
    check("reset result", 64'(bus.RESULT), 64'd0);
    check("reset rd_out", 64'(bus.RD_OUT), 64'd0);

    for (int v = 0; v < 15; v++) begin
      check($sformatf("vec%0d model", v), 64'(ref_result(vecs[v].f3, vecs[v].a, vecs[v].b)), 64'(vecs[v].exp));
      run_op(vecs[v].f3, vecs[v].a, vecs[v].b, vecs[v].rd, $sformatf("vec%0d", v));
    end

    abort_seq(1'b0, "kill");
    run_op(3'd5, 32'd100, 32'd7, 5'd3, "after_kill");
    abort_seq(1'b1, "midreset");
    run_op(3'd0, 32'd3, 32'd3, 5'd7, "after_reset");

    // Back-to-back: second START in the DONE cycle of the first op.
    bus.START = 1'b1; bus.FUNCT3 = 3'd0; bus.OPA = 32'd7; bus.OPB = 32'd6; bus.RD_IN = 5'd5;
    @(posedge clk); #1;
    bus.START = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.DONE) seen = 1'b1;
    end
    check("b2b first done", 64'(seen), 64'd1);
    check("b2b first result", 64'(bus.RESULT), 64'd42);
    bus.START = 1'b1; bus.FUNCT3 = 3'd5; bus.OPA = 32'd100; bus.OPB = 32'd7; bus.RD_IN = 5'd9;
    @(posedge clk); #1;
    bus.START = 1'b0;
    check("b2b second accepted", 64'(bus.BUSY), 64'd1);
    check("b2b first result intact", 64'(bus.RESULT), 64'd42);
    check("b2b first rd intact", 64'(bus.RD_OUT), 64'd5);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.DONE) seen = 1'b1;
    end
    check("b2b second done", 64'(seen), 64'd1);
    check("b2b second latency", 64'(lat), 64'd33);
    check("b2b second result", 64'(bus.RESULT), 64'd14);
    check("b2b second rd", 64'(bus.RD_OUT), 64'd9);
    @(posedge clk); #1;

    for (int r = 0; r < 40; r++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(f3, a, b, 5'($urandom_range(0, 31)), $sformatf("rnd%0d f3=%0d a=%h b=%h", r, f3, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
